mem_access: RTL and testbench

//  Memory-access stage controller between the execute-stage register and the store pipeline register.
//  - Decodes RV32I loads/stores from the incoming instruction and drives a ready-handshaked data memory.
//  - Aligns store data and byte enables; extracts and sign/zero-extends load data.
//  - Presents data/mem_data/instr to the store register, which captures every clock.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_align.sv | 76 +++++++
 rtl/mem_access.sv | 145 ++++++++++++++
 tb/tb_mem_access.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage: RV32I opcodes, funct3 codes, bubble, FSM states.
// No logic; pure definitions.
// Imported by mem_align and mem_access.
package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Load/store lane logic: decode, misalign/invalid check, store byte enables/data, load extract+extend.
// Latency: purely combinational.
// Backpressure: none; the caller decides when results are used.
module mem_align
    import mem_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic        o_is_mem,
    output logic        o_is_store,
    output logic        o_bad,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic        w_is_load;
    logic        w_invalid;
    logic        w_misalign;
    logic [31:0] w_lane;

    // Decode the request side: op class, legality and store lane placement
    always_comb begin
        w_is_load  = (i_opcode == OP_LOAD);
        o_is_store = (i_opcode == OP_STORE);
        o_is_mem   = w_is_load || o_is_store;

        w_invalid = 1'b0;
        if (w_is_load) begin
            w_invalid = !(i_funct3 == F3_LB || i_funct3 == F3_LH || i_funct3 == F3_LW ||
                          i_funct3 == F3_LBU || i_funct3 == F3_LHU);
        end else if (o_is_store) begin
            w_invalid = !(i_funct3 == F3_SB || i_funct3 == F3_SH || i_funct3 == F3_SW);
        end

        // funct3[1:0] gives the access size for both loads and stores
        w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
        o_bad      = o_is_mem && (w_invalid || w_misalign);

        o_be    = 4'b0000;
        o_wdata = i_rs2;
        if (o_is_store) begin
            case (i_funct3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_rs2[7:0]}};
                end
                F3_SH: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_rs2[15:0]}};
                end
                F3_SW:   o_be = 4'b1111;
                default: o_be = 4'b0000;
            endcase
        end
    end

    // Shift the addressed lane down and extend it per the latched load type
    always_comb begin
        w_lane = i_rdata >> {i_ld_off, 3'b000};
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_LH:   o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_LBU:  o_ld_data = {24'h0, w_lane[7:0]};
            F3_LHU:  o_ld_data = {16'h0, w_lane[15:0]};
            default: o_ld_data = w_lane;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage controller: drives a ready-handshaked data memory for RV32I loads/stores.
// Latency: non-memory ops 0 cycles; memory ops 1 (IDLE) + N (ACCESS) + 1 (RESP) cycles.
// Backpressure: stall held high (NOP bubble to store stage) from request cycle until dmem_ready.
module mem_access
    import mem_pkg::*;
#(
    parameter int          DWIDTH = 32,
    parameter int          AWIDTH = 32,
    parameter logic [31:0] NOP    = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] ex_data,
    input  logic [DWIDTH-1:0] ex_rs2,
    input  logic [DWIDTH-1:0] ex_instr,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [DWIDTH-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [DWIDTH-1:0] data,
    output logic [DWIDTH-1:0] mem_data,
    output logic [DWIDTH-1:0] instr,
    output logic              mem_err
);

    state_t              r_state;
    logic                r_req;
    logic                r_we;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wdata;
    logic [3:0]          r_be;
    logic [DWIDTH-1:0]   r_data;
    logic [DWIDTH-1:0]   r_mem_data;
    logic [DWIDTH-1:0]   r_instr;
    logic [1:0]          r_off;
    logic                r_err;

    logic                w_is_mem;
    logic                w_is_store;
    logic                w_bad;
    logic                w_go;
    logic [3:0]          w_be;
    logic [DWIDTH-1:0]   w_wdata;
    logic [DWIDTH-1:0]   w_ld_data;

    mem_align u_align (
        .i_opcode    (ex_instr[6:0]),
        .i_funct3    (ex_instr[14:12]),
        .i_addr_lo   (ex_data[1:0]),
        .i_rs2       (ex_rs2),
        .i_ld_funct3 (r_instr[14:12]),
        .i_ld_off    (r_off),
        .i_rdata     (dmem_rdata),
        .o_is_mem    (w_is_mem),
        .o_is_store  (w_is_store),
        .o_bad       (w_bad),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_ld_data   (w_ld_data)
    );

    assign w_go = (r_state == ST_IDLE) && w_is_mem && !w_bad;

    // FSM: issue request, hold it until ready, capture result, present it for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'b0000;
            r_data     <= '0;
            r_mem_data <= '0;
            r_instr    <= '0;
            r_off      <= 2'b00;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_err <= w_is_mem && w_bad;
                    if (w_go) begin
                        r_data  <= ex_data;
                        r_instr <= ex_instr;
                        r_off   <= ex_data[1:0];
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {ex_data[AWIDTH-1:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ready) begin
                        r_req      <= 1'b0;
                        r_mem_data <= (r_instr[6:0] == OP_LOAD) ? w_ld_data : '0;
                        r_state    <= ST_RESP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output mux: pass-through in IDLE, bubble while busy, latched result in RESP
    always_comb begin
        stall    = 1'b0;
        data     = ex_data;
        mem_data = '0;
        instr    = ex_instr;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    stall = !w_bad;
                    data  = '0;
                    instr = NOP;
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                data  = '0;
                instr = NOP;
            end
            default: begin
                data     = r_data;
                mem_data = r_mem_data;
                instr    = r_instr;
            end
        endcase
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign mem_err    = r_err;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table of load/store vectors plus hand-written corner sequences.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Every wait is a fixed number of cycles, so the run always terminates.
module tb_mem_access;

    localparam logic [31:0] C_NOP = 32'h0000_0013;
    localparam logic [31:0] C_ADD = 32'h0031_00B3;  // add x1,x2,x3

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_data, ex_rs2, ex_instr;
    logic        stall, dmem_req, dmem_we, dmem_ready, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, data, mem_data, instr;
    logic [3:0]  dmem_be;

    int n_tests = 0;
    int n_fail  = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk        (clk),
        .rst        (rst),
        .ex_data    (ex_data),
        .ex_rs2     (ex_rs2),
        .ex_instr   (ex_instr),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .data       (data),
        .mem_data   (mem_data),
        .instr      (instr),
        .mem_err    (mem_err)
    );

    // Count distinct memory requests (0->1 transitions of dmem_req)
    always @(negedge clk) begin
        if (dmem_req && !req_prev) req_rises++;
        req_prev = dmem_req;
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          nwait;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr_exp;
        logic [31:0] mdata;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] addr;
    } bad_t;

    function automatic logic [31:0] ld(input logic [2:0] f3);
        return {12'h000, 5'd2, f3, 5'd1, 7'b0000011};
    endfunction

    function automatic logic [31:0] st(input logic [2:0] f3);
        return {7'h00, 5'd3, 5'd2, f3, 5'd0, 7'b0100011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full memory op starting in IDLE; returns 1ns after the RESP->IDLE edge
    task automatic run_mem(input vec_t v);
        ex_data    = v.addr;
        ex_rs2     = v.rs2;
        ex_instr   = v.instr;
        dmem_ready = 1'b1;              // must be ignored in IDLE
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk({v.name, " idle stall"}, {31'h0, stall}, 32'h1);
        chk({v.name, " idle instr"}, instr, C_NOP);
        chk({v.name, " idle req"}, {31'h0, dmem_req}, 32'h0);
        step();
        for (int j = 1; j <= v.nwait; j++) begin
            dmem_ready = (j == v.nwait);
            dmem_rdata = (j == v.nwait) ? v.rdata : 32'h5A5A_5A5A;
            @(negedge clk);
            chk({v.name, " acc stall"}, {31'h0, stall}, 32'h1);
            chk({v.name, " acc instr"}, instr, C_NOP);
            chk({v.name, " acc req"}, {31'h0, dmem_req}, 32'h1);
            chk({v.name, " acc we"}, {31'h0, dmem_we}, {31'h0, v.we});
            chk({v.name, " acc addr"}, dmem_addr, v.addr_exp);
            chk({v.name, " acc be"}, {28'h0, dmem_be}, {28'h0, v.be});
            if (v.we) chk({v.name, " acc wdata"}, dmem_wdata, v.wdata);
            step();
        end
        dmem_ready = 1'b1;              // must be ignored in RESP
        dmem_rdata = 32'h0;
        @(negedge clk);
        chk({v.name, " resp stall"}, {31'h0, stall}, 32'h0);
        chk({v.name, " resp instr"}, instr, v.instr);
        chk({v.name, " resp data"}, data, v.addr);
        chk({v.name, " resp mem_data"}, mem_data, v.mdata);
        chk({v.name, " resp req"}, {31'h0, dmem_req}, 32'h0);
        step();
        ex_instr   = C_ADD;
        dmem_ready = 1'b0;
    endtask

    vec_t vecs[8];
    bad_t bads[5];
    int   base;

    initial begin
        vecs[0] = '{"lw",  ld(3'd2), 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 4'b0000, 32'h0,        32'h100, 32'hDEADBEEF};
        vecs[1] = '{"lb",  ld(3'd0), 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'b0000, 32'h0,        32'h100, 32'hFFFFFF80};
        vecs[2] = '{"lbu", ld(3'd4), 32'h103, 32'h0,        32'h80FF0000, 2, 1'b0, 4'b0000, 32'h0,        32'h100, 32'h00000080};
        vecs[3] = '{"lhu", ld(3'd5), 32'h102, 32'h0,        32'h80FF0000, 1, 1'b0, 4'b0000, 32'h0,        32'h100, 32'h000080FF};
        vecs[4] = '{"lh",  ld(3'd1), 32'h100, 32'h0,        32'h12348765, 1, 1'b0, 4'b0000, 32'h0,        32'h100, 32'hFFFF8765};
        vecs[5] = '{"sh",  st(3'd1), 32'h202, 32'h1234ABCD, 32'h0,        2, 1'b1, 4'b1100, 32'hABCDABCD, 32'h200, 32'h0};
        vecs[6] = '{"sb",  st(3'd0), 32'h201, 32'h000000A5, 32'hFFFFFFFF, 1, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h200, 32'h0};
        vecs[7] = '{"sw",  st(3'd2), 32'h204, 32'hCAFEF00D, 32'h0,        1, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h204, 32'h0};

        bads[0] = '{"lw mis",  ld(3'd2), 32'h101};
        bads[1] = '{"lh mis",  ld(3'd1), 32'h103};
        bads[2] = '{"sw mis",  st(3'd2), 32'h206};
        bads[3] = '{"ld f3=3", ld(3'd3), 32'h100};
        bads[4] = '{"st f3=3", st(3'd3), 32'h100};

        // Reset state
        rst = 1'b1;
        ex_data = 32'h55; ex_rs2 = 32'h0; ex_instr = 32'h0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        chk("rst req",   {31'h0, dmem_req}, 32'h0);
        chk("rst we",    {31'h0, dmem_we}, 32'h0);
        chk("rst addr",  dmem_addr, 32'h0);
        chk("rst wdata", dmem_wdata, 32'h0);
        chk("rst be",    {28'h0, dmem_be}, 32'h0);
        chk("rst err",   {31'h0, mem_err}, 32'h0);
        chk("rst stall", {31'h0, stall}, 32'h0);
        chk("rst data",  data, 32'h55);
        chk("rst instr", instr, 32'h0);
        step();
        rst = 1'b0;
        ex_instr = C_ADD;
        step();

        // Table-driven loads and stores
        foreach (vecs[i]) run_mem(vecs[i]);

        // Misaligned / invalid funct3: no request, one-cycle error pulse
        foreach (bads[i]) begin
            ex_instr = bads[i].instr;
            ex_data  = bads[i].addr;
            @(negedge clk);
            chk({bads[i].name, " stall"}, {31'h0, stall}, 32'h0);
            chk({bads[i].name, " instr"}, instr, C_NOP);
            chk({bads[i].name, " req"},   {31'h0, dmem_req}, 32'h0);
            step();
            ex_instr = C_ADD;
            @(negedge clk);
            chk({bads[i].name, " err"},   {31'h0, mem_err}, 32'h1);
            chk({bads[i].name, " req2"},  {31'h0, dmem_req}, 32'h0);
            step();
            @(negedge clk);
            chk({bads[i].name, " err end"}, {31'h0, mem_err}, 32'h0);
            step();
        end

        // add then lw back-to-back: add passes, lw produces exactly one request
        ex_instr = C_ADD;
        ex_data  = 32'h77;
        @(negedge clk);
        chk("b2b add stall", {31'h0, stall}, 32'h0);
        chk("b2b add instr", instr, C_ADD);
        chk("b2b add data",  data, 32'h77);
        base = req_rises;
        step();
        run_mem(vecs[0]);
        chk("b2b req count", req_rises, base + 1);

        // Reset in the middle of an access
        ex_instr = ld(3'd2);
        ex_data  = 32'h300;
        dmem_ready = 1'b0;
        step();
        @(negedge clk);
        chk("mid rst req before", {31'h0, dmem_req}, 32'h1);
        #1 rst = 1'b1;
        ex_instr = C_ADD;
        ex_data  = 32'h99;
        #1;
        chk("mid rst req async", {31'h0, dmem_req}, 32'h0);
        chk("mid rst err async", {31'h0, mem_err}, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post rst stall", {31'h0, stall}, 32'h0);
        chk("post rst instr", instr, C_ADD);
        chk("post rst data",  data, 32'h99);
        chk("post rst req",   {31'h0, dmem_req}, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
